mem_2r2w_ctrl: RTL and testbench
================================

Name: mem_2r2w_ctrl

Overview:
Client-side controller sitting directly upstream of a 2-read/2-write memory atom. Sequences reset-time initialization of the array and resolves same-address write collisions. Aligns writes with the atom's SRAM_DELAY read pipeline so every client read returns issue-time data with write-first semantics. Registers read data back to the client with a valid strobe.

Parameters:
NUMADDR, 8, number of words
BITADDR, 3, address width (clog2 NUMADDR)
BITDATA, 1, data width
SRAM_DELAY, 0, atom read latency in cycles (0..4)
RSTINIT, 0, 1 = write init pattern after reset; 0 = skip init
RSTSTRT, 0, init value of word 0
RSTINCR, 0, init increment per address

Ports:
clk  in  1  clock
rst  in  1  reset; one clock, synchronous, active-high
ready  out  1  1 = client ports accepted
read_0 / read_1  in  1  client read strobes
rd_adr_0 / rd_adr_1  in  BITADDR  client read addresses
rd_vld_0 / rd_vld_1  out  1  read data valid
rd_dout_0 / rd_dout_1  out  BITDATA  read data
write_2 / write_3  in  1  client write strobes
wr_adr_2 / wr_adr_3  in  BITADDR  client write addresses
wr_din_2 / wr_din_3  in  BITDATA  client write data
m_read_0 / m_read_1  out  1  atom read strobes
m_rd_adr_0 / m_rd_adr_1  out  BITADDR  atom read addresses
m_rd_dout_0 / m_rd_dout_1  in  BITDATA  atom read data, SRAM_DELAY after m_read
m_write_2 / m_write_3  out  1  atom write strobes
m_wr_adr_2 / m_wr_adr_3  out  BITADDR  atom write addresses
m_wr_din_2 / m_wr_din_3  out  BITDATA  atom write data

Behaviour:
- Reset: ready=0; rd_vld_*=0; rd_dout_*=0; all m_read/m_write=0; every pipeline stage and init counter cleared; FSM=RESET.
- FSM: RESET -> INIT if RSTINIT, else READY (first cycle after rst low).
- INIT: cnt 0..NUMADDR-1, one per cycle on port 2 only: m_wr_adr_2=cnt, m_wr_din_2=RSTSTRT+cnt*RSTINCR, truncated to BITDATA.
- INIT -> READY after cnt=NUMADDR-1 is written; NUMADDR cycles total. ready goes high the cycle after the last init write.
- rst in any state returns to RESET on the next edge and flushes all in-flight reads (rd_vld=0) and delayed writes. No partial init is resumed.
- While ready=0, client strobes are ignored (no atom access, no rd_vld).
- Collision: write_2 && write_3 && wr_adr_2==wr_adr_3 -> port 2 write dropped; port 3 wins.
- Write alignment: client writes pass through a SRAM_DELAY-cycle delay line before reaching m_write_*. A read issued at cycle t is presented to the atom at t and sampled at t+SRAM_DELAY. It therefore sees exactly the client writes issued at cycles < t.
- Write-first: a read at cycle t also returns same-cycle writes (cycle t) to its address.
  - Priority: port 3 > port 2 > memory data.
  - Match flag and data travel alongside the read for SRAM_DELAY cycles; muxed at the output register.
- Read latency L = SRAM_DELAY+1. rd_vld_n and rd_dout_n are asserted at t+L for one cycle. rd_dout holds its last value when rd_vld=0.
- Both read ports are independent. The same address may be read on both ports in the same cycle.
- Reads and writes are fully pipelined; no backpressure.
- Writes still in the delay line when a read samples memory are not forwarded. None are lost, because write alignment already orders them.

Decomposition:
- Shared package mem_ctrl_pkg: FSM state enum {RESET, INIT, READY}; helper function init_value(idx) = RSTSTRT+idx*RSTINCR.
- Sub-modules: reuse the codebase's existing shift delay utility for the write delay line and the read-forwarding pipeline (BITDATA widened with match bit). No new sub-module.

Test Plan:
(Config for all: NUMADDR=8, BITDATA=8, SRAM_DELAY=2, RSTINIT=1, RSTSTRT=5, RSTINCR=3, atom model attached.)
1. Release rst -> exactly 8 m_write_2 pulses with data 5,8,11,...,26; ready rises on the 10th cycle after release. Read adr 7 -> rd_dout=26, rd_vld at t+3.
2. write_2 adr3=0xAA and write_3 adr3=0x55 same cycle; read adr3 next cycle -> 0x55. Only m_write_3 fires for adr3.
3. read_0 adr4 and write_3 adr4=0x11 same cycle -> rd_dout_0=0x11 at t+3. read_1 adr4 issued one cycle earlier -> returns 17 (init value).
4. Back-to-back reads on both ports every cycle for 20 cycles interleaved with random writes -> all data matches a scoreboard under issue-time write-first semantics; rd_vld pattern equals read pattern delayed 3.
5. Assert rst for 1 cycle mid-INIT (cnt=4) and again with reads in flight -> rd_vld stays 0; init restarts from adr 0; ready follows 10 cycles later.
6. RSTINIT=0 -> no init writes; ready=1 the first cycle after rst low. Strobes issued while ready=0 produce no atom traffic.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the 2R2W memory controller.
package mem_ctrl_pkg;

   typedef enum logic [1:0] {RESET, INIT, READY} state_t;

   function automatic logic [31:0] init_value(input logic [31:0] idx,
                                              input logic [31:0] strt,
                                              input logic [31:0] incr);
      return strt + idx * incr;
   endfunction

endpackage

// File: rtl/mem_2r2w_ctrl_shift.sv
// Fixed-latency shift delay line, cleared on reset; DELAY=0 is a plain wire.
module mem_2r2w_ctrl_shift #(
   parameter int WIDTH = 1,
   parameter int DELAY = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   generate
      if (DELAY == 0) begin : g_wire
         logic unused_ok;
         assign unused_ok = clk ^ rst;
         assign dout = din;
      end else begin : g_pipe
         logic [DELAY-1:0][WIDTH-1:0] stage;
         always_ff @(posedge clk) begin
            if (rst) begin
               stage <= '0;
            end else begin
               stage[0] <= din;
               for (int i = 1; i < DELAY; i++) stage[i] <= stage[i-1];
            end
         end
         assign dout = stage[DELAY-1];
      end
   endgenerate

endmodule

// File: rtl/mem_2r2w_ctrl.sv
// Client-side controller for a 2R2W memory atom: reset-time init, write
// collision resolution, write alignment to read latency and write-first forwarding.
module mem_2r2w_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int NUMADDR    = 8,
   parameter int BITADDR    = 3,
   parameter int BITDATA    = 1,
   parameter int SRAM_DELAY = 0,
   parameter int RSTINIT    = 0,
   parameter int RSTSTRT    = 0,
   parameter int RSTINCR    = 0
) (
   input  logic               clk,
   input  logic               rst,
   output logic               ready,
   input  logic               read_0,
   input  logic [BITADDR-1:0] rd_adr_0,
   input  logic               read_1,
   input  logic [BITADDR-1:0] rd_adr_1,
   output logic               rd_vld_0,
   output logic [BITDATA-1:0] rd_dout_0,
   output logic               rd_vld_1,
   output logic [BITDATA-1:0] rd_dout_1,
   input  logic               write_2,
   input  logic [BITADDR-1:0] wr_adr_2,
   input  logic [BITDATA-1:0] wr_din_2,
   input  logic               write_3,
   input  logic [BITADDR-1:0] wr_adr_3,
   input  logic [BITDATA-1:0] wr_din_3,
   output logic               m_read_0,
   output logic [BITADDR-1:0] m_rd_adr_0,
   output logic               m_read_1,
   output logic [BITADDR-1:0] m_rd_adr_1,
   input  logic [BITDATA-1:0] m_rd_dout_0,
   input  logic [BITDATA-1:0] m_rd_dout_1,
   output logic               m_write_2,
   output logic [BITADDR-1:0] m_wr_adr_2,
   output logic [BITDATA-1:0] m_wr_din_2,
   output logic               m_write_3,
   output logic [BITADDR-1:0] m_wr_adr_3,
   output logic [BITDATA-1:0] m_wr_din_3
);

   localparam int WW = 1 + BITADDR + BITDATA;
   localparam int RW = 2 + BITDATA;

   state_t             state, state_nxt;
   logic [BITADDR-1:0] cnt;
   logic               active;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RESET;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= (state == INIT) ? cnt + 1'b1 : '0;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RESET:   state_nxt = (RSTINIT != 0) ? INIT : READY;
         INIT:    if (cnt == BITADDR'(NUMADDR - 1)) state_nxt = READY;
         default: state_nxt = state;
      endcase
   end

   assign ready  = (state == READY);
   // A reset cycle must not leak new traffic even while the state still reads READY.
   assign active = ready & ~rst;

   // Same-address collision: port 3 wins, port 2 is dropped.
   logic wen_2, wen_3;
   assign wen_3 = active & write_3;
   assign wen_2 = active & write_2 & ~(write_3 & (wr_adr_2 == wr_adr_3));

   logic [WW-1:0] wd2_q, wd3_q;

   mem_2r2w_ctrl_shift #(.WIDTH(WW), .DELAY(SRAM_DELAY)) u_wdly_2 (
      .clk(clk), .rst(rst), .din({wen_2, wr_adr_2, wr_din_2}), .dout(wd2_q));

   mem_2r2w_ctrl_shift #(.WIDTH(WW), .DELAY(SRAM_DELAY)) u_wdly_3 (
      .clk(clk), .rst(rst), .din({wen_3, wr_adr_3, wr_din_3}), .dout(wd3_q));

   logic [BITDATA-1:0] init_din;
   assign init_din = BITDATA'(init_value(32'(cnt), 32'(RSTSTRT), 32'(RSTINCR)));

   always_comb begin
      {m_write_2, m_wr_adr_2, m_wr_din_2} = wd2_q;
      if (state == INIT) begin
         m_write_2  = 1'b1;
         m_wr_adr_2 = cnt;
         m_wr_din_2 = init_din;
      end
   end

   assign {m_write_3, m_wr_adr_3, m_wr_din_3} = wd3_q;

   logic [1:0]              rd_req;
   logic [1:0][BITADDR-1:0] rd_adr;
   logic [1:0][BITDATA-1:0] m_dout;

   assign rd_req     = {read_1, read_0} & {2{active}};
   assign rd_adr     = {rd_adr_1, rd_adr_0};
   assign m_dout     = {m_rd_dout_1, m_rd_dout_0};
   assign m_read_0   = rd_req[0];
   assign m_read_1   = rd_req[1];
   assign m_rd_adr_0 = rd_adr_0;
   assign m_rd_adr_1 = rd_adr_1;

   // Same-cycle write hits ride with the read so the atom data can be overridden on return.
   for (genvar p = 0; p < 2; p++) begin : g_rd
      logic               hit2, hit3;
      logic [BITDATA-1:0] fwd;
      logic [RW-1:0]      rq;
      logic               vld_q;
      logic [BITDATA-1:0] dout_q;

      assign hit3 = wen_3 & (wr_adr_3 == rd_adr[p]);
      assign hit2 = wen_2 & (wr_adr_2 == rd_adr[p]);
      assign fwd  = hit3 ? wr_din_3 : wr_din_2;

      mem_2r2w_ctrl_shift #(.WIDTH(RW), .DELAY(SRAM_DELAY)) u_rfwd (
         .clk(clk), .rst(rst), .din({rd_req[p], hit2 | hit3, fwd}), .dout(rq));

      always_ff @(posedge clk) begin
         if (rst) begin
            vld_q  <= 1'b0;
            dout_q <= '0;
         end else begin
            vld_q <= rq[RW-1];
            if (rq[RW-1]) dout_q <= rq[RW-2] ? rq[BITDATA-1:0] : m_dout[p];
         end
      end
   end

   assign rd_vld_0  = g_rd[0].vld_q;
   assign rd_dout_0 = g_rd[0].dout_q;
   assign rd_vld_1  = g_rd[1].vld_q;
   assign rd_dout_1 = g_rd[1].dout_q;

endmodule

// File: tb/tb_mem_2r2w_ctrl.sv
// Self-checking bench for mem_2r2w_ctrl with behavioural atom models.
module tb_mem_2r2w_ctrl;

   localparam int NA = 8;
   localparam int BA = 3;
   localparam int BD = 8;
   localparam int SD = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, rst_b;
   logic read_0, read_1, write_2, write_3;
   logic [BA-1:0] rd_adr_0, rd_adr_1, wr_adr_2, wr_adr_3;
   logic [BD-1:0] wr_din_2, wr_din_3;

   logic ready, rd_vld_0, rd_vld_1, m_read_0, m_read_1, m_write_2, m_write_3;
   logic [BD-1:0] rd_dout_0, rd_dout_1, m_rd_dout_0, m_rd_dout_1, m_wr_din_2, m_wr_din_3;
   logic [BA-1:0] m_rd_adr_0, m_rd_adr_1, m_wr_adr_2, m_wr_adr_3;

   logic ready_b, rd_vld_0_b, rd_vld_1_b, m_read_0_b, m_read_1_b, m_write_2_b, m_write_3_b;
   logic [BD-1:0] rd_dout_0_b, rd_dout_1_b, m_rd_dout_0_b, m_rd_dout_1_b, m_wr_din_2_b, m_wr_din_3_b;
   logic [BA-1:0] m_rd_adr_0_b, m_rd_adr_1_b, m_wr_adr_2_b, m_wr_adr_3_b;

   mem_2r2w_ctrl #(.NUMADDR(NA), .BITADDR(BA), .BITDATA(BD), .SRAM_DELAY(SD),
                   .RSTINIT(1), .RSTSTRT(5), .RSTINCR(3)) dut (
      .clk(clk), .rst(rst), .ready(ready),
      .read_0(read_0), .rd_adr_0(rd_adr_0), .read_1(read_1), .rd_adr_1(rd_adr_1),
      .rd_vld_0(rd_vld_0), .rd_dout_0(rd_dout_0), .rd_vld_1(rd_vld_1), .rd_dout_1(rd_dout_1),
      .write_2(write_2), .wr_adr_2(wr_adr_2), .wr_din_2(wr_din_2),
      .write_3(write_3), .wr_adr_3(wr_adr_3), .wr_din_3(wr_din_3),
      .m_read_0(m_read_0), .m_rd_adr_0(m_rd_adr_0), .m_read_1(m_read_1), .m_rd_adr_1(m_rd_adr_1),
      .m_rd_dout_0(m_rd_dout_0), .m_rd_dout_1(m_rd_dout_1),
      .m_write_2(m_write_2), .m_wr_adr_2(m_wr_adr_2), .m_wr_din_2(m_wr_din_2),
      .m_write_3(m_write_3), .m_wr_adr_3(m_wr_adr_3), .m_wr_din_3(m_wr_din_3));

   mem_2r2w_ctrl #(.NUMADDR(NA), .BITADDR(BA), .BITDATA(BD), .SRAM_DELAY(SD),
                   .RSTINIT(0), .RSTSTRT(5), .RSTINCR(3)) dut_b (
      .clk(clk), .rst(rst_b), .ready(ready_b),
      .read_0(read_0), .rd_adr_0(rd_adr_0), .read_1(read_1), .rd_adr_1(rd_adr_1),
      .rd_vld_0(rd_vld_0_b), .rd_dout_0(rd_dout_0_b), .rd_vld_1(rd_vld_1_b), .rd_dout_1(rd_dout_1_b),
      .write_2(write_2), .wr_adr_2(wr_adr_2), .wr_din_2(wr_din_2),
      .write_3(write_3), .wr_adr_3(wr_adr_3), .wr_din_3(wr_din_3),
      .m_read_0(m_read_0_b), .m_rd_adr_0(m_rd_adr_0_b), .m_read_1(m_read_1_b), .m_rd_adr_1(m_rd_adr_1_b),
      .m_rd_dout_0(m_rd_dout_0_b), .m_rd_dout_1(m_rd_dout_1_b),
      .m_write_2(m_write_2_b), .m_wr_adr_2(m_wr_adr_2_b), .m_wr_din_2(m_wr_din_2_b),
      .m_write_3(m_write_3_b), .m_wr_adr_3(m_wr_adr_3_b), .m_wr_din_3(m_wr_din_3_b));

   // Atom models: reads sample memory SD cycles after issue.
   logic [BD-1:0] mem_a [NA];
   logic [BD-1:0] mem_b [NA];
   logic [1:0][BA-1:0] aa0, aa1, ab0, ab1;

   initial begin
      for (int i = 0; i < NA; i++) begin
         mem_a[i] = '0;
         mem_b[i] = '0;
      end
   end

   always @(posedge clk) begin
      if (m_write_2) mem_a[m_wr_adr_2] <= m_wr_din_2;
      if (m_write_3) mem_a[m_wr_adr_3] <= m_wr_din_3;
      if (m_write_2_b) mem_b[m_wr_adr_2_b] <= m_wr_din_2_b;
      if (m_write_3_b) mem_b[m_wr_adr_3_b] <= m_wr_din_3_b;
      aa0 <= {aa0[0], m_rd_adr_0};
      aa1 <= {aa1[0], m_rd_adr_1};
      ab0 <= {ab0[0], m_rd_adr_0_b};
      ab1 <= {ab1[0], m_rd_adr_1_b};
   end

   assign m_rd_dout_0   = mem_a[aa0[1]];
   assign m_rd_dout_1   = mem_a[aa1[1]];
   assign m_rd_dout_0_b = mem_b[ab0[1]];
   assign m_rd_dout_1_b = mem_b[ab1[1]];

   typedef struct { int due; logic [BD-1:0] d; } exp_t;
   exp_t q0[$];
   exp_t q1[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit tb_ready = 0;
   bit chk_en = 0;
   logic [BD-1:0] ref_mem [NA];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard drain: every read accepted by dut must return exactly 3 cycles later.
   always @(negedge clk) begin
      if (chk_en) begin
         if (q0.size() > 0 && q0[0].due == cyc) begin
            chk("rd_vld_0", 32'(rd_vld_0), 1);
            chk("rd_dout_0", 32'(rd_dout_0), 32'(q0[0].d));
            void'(q0.pop_front());
         end else chk("rd_vld_0 idle", 32'(rd_vld_0), 0);
         if (q1.size() > 0 && q1[0].due == cyc) begin
            chk("rd_vld_1", 32'(rd_vld_1), 1);
            chk("rd_dout_1", 32'(rd_dout_1), 32'(q1[0].d));
            void'(q1.pop_front());
         end else chk("rd_vld_1 idle", 32'(rd_vld_1), 0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear();
      read_0 = 0; read_1 = 0; write_2 = 0; write_3 = 0;
   endtask

   function automatic logic [BD-1:0] exp_rd(input logic [BA-1:0] a,
         input logic w2, input logic [BA-1:0] wa2, input logic [BD-1:0] wd2,
         input logic w3, input logic [BA-1:0] wa3, input logic [BD-1:0] wd3);
      if (w3 && wa3 == a) return wd3;
      if (w2 && wa2 == a) return wd2;
      return ref_mem[a];
   endfunction

   task automatic step(input logic r0, input logic [BA-1:0] a0,
                       input logic r1, input logic [BA-1:0] a1,
                       input logic w2, input logic [BA-1:0] wa2, input logic [BD-1:0] wd2,
                       input logic w3, input logic [BA-1:0] wa3, input logic [BD-1:0] wd3);
      read_0 = r0; rd_adr_0 = a0; read_1 = r1; rd_adr_1 = a1;
      write_2 = w2; wr_adr_2 = wa2; wr_din_2 = wd2;
      write_3 = w3; wr_adr_3 = wa3; wr_din_3 = wd3;
      if (tb_ready) begin
         if (r0) q0.push_back('{cyc + 3, exp_rd(a0, w2, wa2, wd2, w3, wa3, wd3)});
         if (r1) q1.push_back('{cyc + 3, exp_rd(a1, w2, wa2, wd2, w3, wa3, wd3)});
         if (w2 && !(w3 && wa2 == wa3)) ref_mem[wa2] = wd2;
         if (w3) ref_mem[wa3] = wd3;
      end
      tick();
      clear();
   endtask

   task automatic idle(input int n);
      repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Entered in the first cycle after a reset edge; abort_k>0 re-asserts rst at that cycle.
   task automatic run_init(input int abort_k);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         chk($sformatf("ready k%0d", k), 32'(ready), (k == 10) ? 1 : 0);
         if (k >= 2 && k <= 9) begin
            chk($sformatf("init m_write_2 k%0d", k), 32'(m_write_2), 1);
            chk($sformatf("init adr k%0d", k), 32'(m_wr_adr_2), 32'(k - 2));
            chk($sformatf("init din k%0d", k), 32'(m_wr_din_2), 32'(8'(5 + 3 * (k - 2))));
         end else chk($sformatf("init m_write_2 k%0d", k), 32'(m_write_2), 0);
         chk($sformatf("init m_write_3 k%0d", k), 32'(m_write_3), 0);
         if (k == abort_k) rst = 1;
         tick();
         if (k == abort_k) begin
            rst = 0;
            return;
         end
      end
   endtask

   task automatic load_init_ref();
      for (int i = 0; i < NA; i++) ref_mem[i] = 8'(5 + 3 * i);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1; rst_b = 1;
      clear();
      rd_adr_0 = 0; rd_adr_1 = 0; wr_adr_2 = 0; wr_adr_3 = 0; wr_din_2 = 0; wr_din_3 = 0;
      repeat (2) tick();
      chk_en = 1;

      // Reset state
      @(negedge clk);
      chk("reset ready", 32'(ready), 0);
      chk("reset m_write_2", 32'(m_write_2), 0);
      chk("reset m_read_0", 32'(m_read_0), 0);
      chk("reset rd_dout_0", 32'(rd_dout_0), 0);
      tick();
      rst = 0;

      // 1: init sequence, then read the last initialized word
      run_init(0);
      load_init_ref();
      tb_ready = 1;
      step(1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(3);

      // 2: same-address write collision, port 3 wins
      step(0, 0, 0, 0, 1, 3, 8'hAA, 1, 3, 8'h55);
      step(1, 3, 1, 3, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("collision m_write_2", 32'(m_write_2), 0);
      chk("collision m_write_3", 32'(m_write_3), 1);
      chk("collision m_wr_adr_3", 32'(m_wr_adr_3), 3);
      chk("collision m_wr_din_3", 32'(m_wr_din_3), 32'h55);
      tick();
      idle(3);

      // 3: write-first on port 0; port 1 read one cycle earlier sees the init value
      step(0, 0, 1, 4, 0, 0, 0, 0, 0, 0);
      step(1, 4, 0, 0, 0, 0, 0, 1, 4, 8'h11);
      idle(4);

      // 4: back-to-back reads on both ports with random writes
      for (int i = 0; i < 20; i++)
         step(1, 3'($urandom_range(0, 7)), 1, 3'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
              1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom));
      idle(4);
      chk("q0 drained", 32'(q0.size()), 0);
      chk("q1 drained", 32'(q1.size()), 0);

      // 5: reset with reads in flight, then reset mid-INIT at cnt=4
      tb_ready = 0;
      step(1, 1, 1, 2, 0, 0, 0, 0, 0, 0);
      rst = 1;
      tick();
      rst = 0;
      run_init(6);
      run_init(0);
      load_init_ref();
      tb_ready = 1;
      step(1, 4, 1, 0, 0, 0, 0, 0, 0, 0);
      idle(4);

      // 6: RSTINIT=0 instance; dut held in reset so it ignores the shared stimulus
      rst = 1;
      tb_ready = 0;
      read_0 = 1; rd_adr_0 = 2; write_2 = 1; wr_adr_2 = 2; wr_din_2 = 8'h33;
      write_3 = 1; wr_adr_3 = 5; wr_din_3 = 8'h44;
      @(negedge clk);
      chk("b rst ready", 32'(ready_b), 0);
      chk("b rst m_read_0", 32'(m_read_0_b), 0);
      chk("b rst m_write_2", 32'(m_write_2_b), 0);
      chk("b rst m_write_3", 32'(m_write_3_b), 0);
      tick();
      rst_b = 0;
      @(negedge clk);
      chk("b c1 ready", 32'(ready_b), 0);
      chk("b c1 m_read_0", 32'(m_read_0_b), 0);
      chk("b c1 m_write_2", 32'(m_write_2_b), 0);
      tick();
      clear();
      read_0 = 1; rd_adr_0 = 2; write_3 = 1; wr_adr_3 = 2; wr_din_3 = 8'h77;
      @(negedge clk);
      chk("b c2 ready", 32'(ready_b), 1);
      chk("b c2 m_read_0", 32'(m_read_0_b), 1);
      chk("b c2 m_rd_adr_0", 32'(m_rd_adr_0_b), 2);
      tick();
      clear();
      @(negedge clk);
      chk("b c3 m_write_3", 32'(m_write_3_b), 0);
      chk("b c3 rd_vld_0", 32'(rd_vld_0_b), 0);
      tick();
      @(negedge clk);
      chk("b c4 m_write_3", 32'(m_write_3_b), 1);
      chk("b c4 m_wr_adr_3", 32'(m_wr_adr_3_b), 2);
      chk("b c4 m_wr_din_3", 32'(m_wr_din_3_b), 32'h77);
      chk("b c4 m_write_2", 32'(m_write_2_b), 0);
      tick();
      read_0 = 1; rd_adr_0 = 5; read_1 = 1; rd_adr_1 = 2;
      @(negedge clk);
      chk("b c5 rd_vld_0", 32'(rd_vld_0_b), 1);
      chk("b c5 rd_dout_0", 32'(rd_dout_0_b), 32'h77);
      tick();
      clear();
      tick();
      tick();
      @(negedge clk);
      chk("b c8 rd_vld_0", 32'(rd_vld_0_b), 1);
      chk("b c8 rd_dout_0", 32'(rd_dout_0_b), 0);
      chk("b c8 rd_vld_1", 32'(rd_vld_1_b), 1);
      chk("b c8 rd_dout_1", 32'(rd_dout_1_b), 32'h77);
      tick();
      @(negedge clk);
      chk("b c9 rd_vld_0", 32'(rd_vld_0_b), 0);
      chk("b c9 rd_dout_0 hold", 32'(rd_dout_0_b), 0);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
